// File: rtl/fft_mag_streamer.sv
`default_nettype none
// ============================================================================
// Module   : fft_mag_streamer
// Function : Squares complex FFT bins (re^2+im^2), buffers one frame and
//            replays it as a single gap-free burst. FFT_MAG_PINGPONG_EN
//            selects a two-bank buffer so filling overlaps draining.
// Revision : 1.0
// ============================================================================
module fft_mag_streamer #(
  parameter int NSamples = 1024,
  parameter int IW       = 16,
  parameter int W        = 2*IW+1,
  parameter int NBits    = $clog2(NSamples)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [IW-1:0] in_re,
  input  logic signed [IW-1:0] in_im,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sop,
  input  logic                 in_eop,
  output logic [W-1:0]         mag,
  output logic                 mag_valid,
  output logic                 frame_err
);

`ifdef FFT_MAG_PINGPONG_EN
  localparam int c_ABITS = NBits + 1;
`else
  localparam int c_ABITS = NBits;
`endif
  localparam logic [NBits-1:0] c_LAST = NBits'(NSamples - 1);

  typedef enum logic {W_FILL = 1'b0, W_WAIT = 1'b1} wr_state_t;
  typedef enum logic {D_IDLE = 1'b0, D_DRAIN = 1'b1} rd_state_t;

  wr_state_t r_wstate, w_wstate_nxt;
  rd_state_t r_dstate, w_dstate_nxt;

  logic [NBits-1:0]       r_wi, w_idx, r_ra, r_p1_idx, r_p2_idx;
  logic                   w_acc, w_sop_err, w_at_last, w_good, w_bad, w_commit;
  logic                   w_wr_busy, w_rd_busy, w_rd_pend, w_rd_en, w_drain_done;
  logic signed [2*IW-1:0] w_re_x, w_im_x;
  logic [2*IW-1:0]        r_sq_re, r_sq_im;
  logic [W-1:0]           r_sum, r_ram_q;
  logic                   r_p1_v, r_p2_v, r_rd_v;
  logic [c_ABITS-1:0]     w_wr_addr, w_rd_addr;
  logic [W-1:0]           r_mem [0:(2**c_ABITS)-1];

  assign in_ready = !reset && (r_wstate == W_FILL) && !w_wr_busy;
  assign w_acc    = in_valid && in_ready;

  // An sop beat always lands at index 0, even when it aborts a partial frame.
  assign w_idx     = in_sop ? '0 : r_wi;
  assign w_sop_err = in_sop && (r_wi != '0);
  assign w_at_last = (w_idx == c_LAST);
  assign w_good    = w_at_last && in_eop;
  assign w_bad     = w_sop_err || (in_eop && !w_at_last) || (w_at_last && !in_eop);
  assign w_commit  = w_acc && w_good;

  assign w_re_x = {{IW{in_re[IW-1]}}, in_re};
  assign w_im_x = {{IW{in_im[IW-1]}}, in_im};

  // Write-side FSM
  always_ff @(posedge clk) begin
    if (reset) r_wstate <= W_FILL;
    else       r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_FILL: if (w_commit) w_wstate_nxt = W_WAIT;
      W_WAIT: w_wstate_nxt = W_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wi      <= '0;
      r_p1_v    <= 1'b0;
      r_p2_v    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_p1_v    <= w_acc;
      r_p2_v    <= r_p1_v;
      frame_err <= w_acc && w_bad;
      if (w_acc) r_wi <= (w_at_last || in_eop) ? '0 : w_idx + 1'b1;
    end
  end

  // Squaring pipeline: products, then the zero-extended sum.
  always_ff @(posedge clk) begin
    r_p1_idx <= w_idx;
    r_sq_re  <= w_re_x * w_re_x;
    r_sq_im  <= w_im_x * w_im_x;
    r_p2_idx <= r_p1_idx;
    r_sum    <= {{(W-2*IW){1'b0}}, r_sq_re} + {{(W-2*IW){1'b0}}, r_sq_im};
  end

  // Drain FSM
  always_ff @(posedge clk) begin
    if (reset) r_dstate <= D_IDLE;
    else       r_dstate <= w_dstate_nxt;
  end

  always_comb begin
    w_dstate_nxt = r_dstate;
    w_rd_en      = 1'b0;
    w_drain_done = 1'b0;
    case (r_dstate)
      // Wait until the last beat has left the product stage; the sum stage
      // writes it long before its address comes up in the drain.
      D_IDLE: if (w_rd_busy && !w_rd_pend) w_dstate_nxt = D_DRAIN;
      D_DRAIN: begin
        w_rd_en = 1'b1;
        if (r_ra == c_LAST) begin
          w_drain_done = 1'b1;
          w_dstate_nxt = D_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ra      <= '0;
      r_rd_v    <= 1'b0;
      mag_valid <= 1'b0;
      mag       <= '0;
    end else begin
      if (w_rd_en) r_ra <= r_ra + 1'b1;
      r_rd_v    <= w_rd_en;
      mag_valid <= r_rd_v;
      mag       <= r_rd_v ? r_ram_q : '0;
    end
  end

`ifdef FFT_MAG_PINGPONG_EN
  logic       r_wb, r_rb, r_p1_bank, r_p2_bank;
  logic [1:0] r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb      <= 1'b0;
      r_rb      <= 1'b0;
      r_p1_bank <= 1'b0;
      r_p2_bank <= 1'b0;
      r_busy    <= '0;
    end else begin
      r_p1_bank <= r_wb;
      r_p2_bank <= r_p1_bank;
      if (w_commit) begin
        r_wb         <= ~r_wb;
        r_busy[r_wb] <= 1'b1;
      end
      if (w_drain_done) begin
        r_rb         <= ~r_rb;
        r_busy[r_rb] <= 1'b0;
      end
    end
  end

  assign w_wr_busy = r_busy[r_wb];
  assign w_rd_busy = r_busy[r_rb];
  assign w_rd_pend = r_p1_v && (r_p1_bank == r_rb);
  assign w_wr_addr = {r_p2_bank, r_p2_idx};
  assign w_rd_addr = {r_rb, r_ra};
`else
  logic r_busy;

  always_ff @(posedge clk) begin
    if (reset)             r_busy <= 1'b0;
    else if (w_commit)     r_busy <= 1'b1;
    else if (w_drain_done) r_busy <= 1'b0;
  end

  assign w_wr_busy = r_busy;
  assign w_rd_busy = r_busy;
  assign w_rd_pend = r_p1_v;
  assign w_wr_addr = r_p2_idx;
  assign w_rd_addr = r_ra;
`endif

  always_ff @(posedge clk) begin
    if (r_p2_v) r_mem[w_wr_addr] <= r_sum;
    r_ram_q <= r_mem[w_rd_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_mag_streamer.sv
`default_nettype none
// Directed-vector bench for fft_mag_streamer (single-bank build).
module tb_fft_mag_streamer;
  localparam int NSamples = 1024;
  localparam int IW       = 16;
  localparam int W        = 2*IW+1;
  localparam int NBits    = 10;

  logic                 clk      = 1'b0;
  logic                 reset    = 1'b1;
  logic signed [IW-1:0] in_re    = '0;
  logic signed [IW-1:0] in_im    = '0;
  logic                 in_valid = 1'b0;
  logic                 in_sop   = 1'b0;
  logic                 in_eop   = 1'b0;
  logic                 in_ready;
  logic [W-1:0]         mag;
  logic                 mag_valid;
  logic                 frame_err;

  fft_mag_streamer #(
    .NSamples(NSamples), .IW(IW), .W(W), .NBits(NBits)
  ) u_dut (
    .clk(clk), .reset(reset), .in_re(in_re), .in_im(in_im),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .mag(mag), .mag_valid(mag_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: beats, burst starts/lengths, error pulses, stall cycles.
  longint q_mag[$];
  int     q_first[$];
  int     q_runs[$];
  int     q_errc[$];
  int     run_len   = 0;
  int     ready_low = 0;

  always @(negedge clk) begin
    if (mag_valid === 1'b1) begin
      if (run_len == 0) q_first.push_back(cyc);
      q_mag.push_back(longint'(mag));
      run_len++;
    end else if (run_len != 0) begin
      q_runs.push_back(run_len);
      run_len = 0;
    end
    if (frame_err === 1'b1) q_errc.push_back(cyc);
    if (reset === 1'b0 && in_ready !== 1'b1) ready_low++;
  end

  task automatic clear_mon();
    q_mag.delete(); q_first.delete(); q_runs.delete(); q_errc.delete();
    ready_low = 0;
  endtask

  function automatic longint mag_at(input int k);
    return (k < q_mag.size()) ? q_mag[k] : -1;
  endfunction
  function automatic int run_at(input int k);
    return (k < q_runs.size()) ? q_runs[k] : -1;
  endfunction
  function automatic int first_at(input int k);
    return (k < q_first.size()) ? q_first[k] : -1;
  endfunction
  function automatic int err_at(input int k);
    return (k < q_errc.size()) ? q_errc[k] : -1;
  endfunction

  function automatic longint exp_mag(input int mode, input int k);
    if (mode == 0) return 25;
    if (k == NSamples - 1) return 64'd2147483648;
    return 2 * longint'(k) * longint'(k);
  endfunction

  function automatic int count_bad(input int mode, input int base);
    int bad = 0;
    for (int i = 0; i < NSamples; i++)
      if (mag_at(base + i) != exp_mag(mode, i)) bad++;
    return bad;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input int re, input int im, input logic sop, input logic eop,
                           output int acc);
    bit got = 1'b0;
    acc = -1;
    in_re = IW'(re); in_im = IW'(im); in_sop = sop; in_eop = eop; in_valid = 1'b1;
    for (int w = 0; w < 4000 && !got; w++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin got = 1'b1; acc = cyc; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!got) check_val("accept_timeout", 0, 1);
  endtask

  // mode 0: re=3,im=4; mode 1: re=k,im=-k with the last bin at full negative scale.
  task automatic send_frame(input int mode, input int nbeats, input int eop_at, input bit gaps,
                            output int t_first, output int t_last);
    int re, im, acc;
    t_first = -1; t_last = -1;
    for (int k = 0; k < nbeats; k++) begin
      if (mode == 0)                 begin re = 3;      im = 4;      end
      else if (k == NSamples - 1)    begin re = -32768; im = -32768; end
      else                           begin re = k;      im = -k;     end
      send_beat(re, im, k == 0, k == eop_at, acc);
      if (k == 0) t_first = acc;
      t_last = acc;
      if (gaps && $urandom_range(0, 1) == 1) idle(1);
    end
  endtask

  int tf, tl, tf2, tl2;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_mag_valid", mag_valid, 0);
    check_val("rst_mag", mag, 0);
    check_val("rst_frame_err", frame_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Constant frame 3+4j
    clear_mon();
    send_frame(0, NSamples, NSamples - 1, 1'b0, tf, tl);
    idle(1100);
    check_val("const_bursts", q_runs.size(), 1);
    check_val("const_len", run_at(0), NSamples);
    check_val("const_first", first_at(0), tl + 5);
    check_val("const_bad", count_bad(0, 0), 0);
    check_val("const_err", q_errc.size(), 0);
    check_val("const_stall", ready_low, NSamples + 2);

    // Ramp frame, order and full-scale bin
    clear_mon();
    send_frame(1, NSamples, NSamples - 1, 1'b0, tf, tl);
    idle(1100);
    check_val("ramp_len", run_at(0), NSamples);
    check_val("ramp_first", first_at(0), tl + 5);
    check_val("ramp_bad", count_bad(1, 0), 0);
    check_val("ramp_beat1", mag_at(1), 2);
    check_val("ramp_beat1022", mag_at(1022), 2088968);
    check_val("ramp_fullscale", mag_at(1023), 64'd2147483648);

    // Ramp with random input gaps
    clear_mon();
    send_frame(1, NSamples, NSamples - 1, 1'b1, tf, tl);
    idle(1100);
    check_val("gap_bursts", q_runs.size(), 1);
    check_val("gap_len", run_at(0), NSamples);
    check_val("gap_first", first_at(0), tl + 5);
    check_val("gap_bad", count_bad(1, 0), 0);

    // Early eop on beat 99, then a good frame
    clear_mon();
    send_frame(0, 100, 99, 1'b0, tf, tl);
    send_frame(1, NSamples, NSamples - 1, 1'b0, tf2, tl2);
    idle(1100);
    check_val("eop_err_count", q_errc.size(), 1);
    check_val("eop_err_cycle", err_at(0), tl + 1);
    check_val("eop_bursts", q_runs.size(), 1);
    check_val("eop_bad", count_bad(1, 0), 0);

    // sop in mid-frame restarts the frame
    clear_mon();
    send_frame(0, 50, -1, 1'b0, tf, tl);
    send_frame(1, NSamples, NSamples - 1, 1'b0, tf2, tl2);
    idle(1100);
    check_val("sop_err_count", q_errc.size(), 1);
    check_val("sop_err_cycle", err_at(0), tf2 + 1);
    check_val("sop_bursts", q_runs.size(), 1);
    check_val("sop_bad", count_bad(1, 0), 0);

    // Last beat without eop
    clear_mon();
    send_frame(1, NSamples, -1, 1'b0, tf, tl);
    idle(1100);
    check_val("noeop_err_cycle", err_at(0), tl + 1);
    check_val("noeop_beats", q_mag.size(), 0);

    // Back-to-back frames
    clear_mon();
    send_frame(0, NSamples, NSamples - 1, 1'b0, tf, tl);
    send_frame(1, NSamples, NSamples - 1, 1'b0, tf2, tl2);
    idle(1100);
    check_val("b2b_restart", tf2 - tl, NSamples + 3);
    check_val("b2b_stall", ready_low, 2 * (NSamples + 2));
    check_val("b2b_bursts", q_runs.size(), 2);
    check_val("b2b_first0", first_at(0), tl + 5);
    check_val("b2b_first1", first_at(1), tl2 + 5);
    check_val("b2b_bad1", count_bad(1, NSamples), 0);

    // Reset at drain beat 500
    clear_mon();
    send_frame(0, NSamples, NSamples - 1, 1'b0, tf, tl);
    while (cyc < tl + 505) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("rstd_mag_valid", mag_valid, 0);
    check_val("rstd_mag", mag, 0);
    check_val("rstd_in_ready", in_ready, 1);
    idle(1200);
    check_val("rstd_partial_len", run_at(0), 501);
    check_val("rstd_total_beats", q_mag.size(), 501);
    check_val("rstd_err", q_errc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_mag_streamer.md
# fft_mag_streamer

Producer side of the pitch-detect magnitude stream. Accepts complex FFT bins (bit-reversed order, with gaps and stalls) from the FFT core and computes squared magnitude re²+im². It buffers a full frame, then emits it as one gap-free burst of NSamples beats on `mag`/`mag_valid`. The peak-finder downstream requires that burst to be contiguous, because it restarts whenever `mag_valid` drops.

## Interface
- `NSamples`, 1024, FFT points per frame (power of two)
- `IW`, 16, signed width of each real/imag input component
- `W`, 2*IW+1, unsigned magnitude output width
- `NBits`, $clog2(NSamples), index/address width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `in_re`  in  IW  signed real part of FFT bin
- `in_im`  in  IW  signed imaginary part of FFT bin
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block can accept a beat; transfer when `in_valid && in_ready`
- `in_sop`  in  1  first bin of frame (qualified by transfer)
- `in_eop`  in  1  last bin of frame (qualified by transfer)
- `mag`  out  W  re²+im², unsigned, registered
- `mag_valid`  out  1  high for exactly NSamples consecutive cycles per frame
- `frame_err`  out  1  one-cycle pulse when a malformed frame is dropped

## Operation
- Arithmetic:
  - Products are signed IW×IW.
  - The sum is zero-extended to W bits; it never overflows. Worst case (-2^(IW-1))² × 2 = 2^(2IW-1).
  - Squaring is pipelined in 2 register stages (products, then sum).
- Frame buffer: NSamples×W RAM with synchronous read. Bin order is preserved exactly; the block does not bit-reverse.
- Write index `wi` counts accepted beats 0..NSamples-1. It is reset to 0 by any accepted `in_sop`.
- Frame validity: a frame is good when the beat at `wi==NSamples-1` carries `in_eop=1`. Malformed frames are discarded, `frame_err` pulses once, and the state stays FILL with `wi=0`. Malformed means any of:
  - `in_eop` arrives at `wi<NSamples-1`;
  - beat NSamples-1 arrives with `in_eop=0`;
  - `in_sop` arrives at `wi!=0`. This case drops the partial frame and the sop beat starts a new frame at `wi=0`.
- State machine (single bank):
  - FILL: `in_ready=1`, write magnitudes. When the last pipelined magnitude of a good frame is written → WAIT.
  - WAIT: `in_ready=0` for one cycle while the write pipeline drains → DRAIN.
  - DRAIN: `in_ready=0`; read addresses 0..NSamples-1 on consecutive cycles; output is registered. After the last beat → FILL.
- `in_ready` drops combinationally-from-state in the cycle after beat NSamples-1 is accepted.

## Timing
- Reset values: `in_ready=0` in the reset cycle then 1 (FILL); `mag=0`, `mag_valid=0`, `frame_err=0`; `wi=0`, read address 0, pipeline valid bits cleared.
- Write latency: beat accepted at cycle t → RAM write at the edge ending cycle t+2.
- Output latency: the last good input beat is accepted at cycle t. The first `mag_valid=1` is at cycle t+5 and stays high through t+4+NSamples. `mag_valid` is low for at least 1 cycle between frames.
- `frame_err` fires in the cycle after the offending beat is accepted.
- Reset mid-DRAIN: `mag_valid` is 0 in the following cycle and the buffered frame is lost.
- Reset mid-FILL: the partial frame is lost and no `frame_err` is raised.
- An input stall (`in_valid=0`) during FILL has no effect on output continuity.

## Configuration
- `FFT_MAG_PINGPONG_EN` defined:
  - Two banks. FILL of one bank proceeds while the other is in DRAIN.
  - `in_ready=0` only when both banks hold complete undrained frames, and during the 1-cycle WAIT.
  - Banks alternate strictly.
- Undefined: single bank, behaviour as above. Input is back-pressured for the whole WAIT+DRAIN period (NSamples+2 cycles).

## Test plan
- Good frame, every bin re=3, im=4, continuous `in_valid` → 1024 consecutive `mag=25` beats, first beat 5 cycles after the eop beat; `frame_err` never asserted.
- Bin k has re=k, im=-k (k=0..1023) → output beat k equals 2k²; order identical to input; the boundary bin carries re=-32768, im=-32768 → `mag`=2147483648.
- Random `in_valid` gaps (50% duty) during fill → output burst still 1024 contiguous `mag_valid` cycles.
- `in_eop` on beat 99, then a good frame → one `frame_err` pulse and exactly one 1024-beat burst (the second frame).
- Back-to-back good frames, single bank: `in_ready` low for 1026 cycles between frames. With `FFT_MAG_PINGPONG_EN`: the second frame fills during the first burst and bursts are separated by 1 idle cycle.
- Reset asserted at drain beat 500 → `mag_valid=0` the next cycle, `mag=0`, `in_ready=1` after reset deasserts, and no residual burst.
